// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding and
// the default operand width.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fa_bit.sv
// One-bit full-adder cell; the only arithmetic in the serial adder.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock, LSB first,
// with a start/busy/done handshake and registered sum/cout.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last;

    fa_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Written as shift-then-insert so WIDTH=1 needs no special slice.
    always_comb begin
        res_next            = res_sh >> 1;
        res_next[WIDTH-1]   = fa_sum;
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        res_sh <= '0;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    res_sh <= res_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        sum   <= res_next;
                        cout  <= fa_cout;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1: the driver predicts
// acceptance edges and results arithmetically, monitors compare every cycle.
module tb_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W:0] res;
        int         acc;
    } exp8_t;

    typedef struct {
        logic [1:0] res;
        int         acc;
    } exp1_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         start1 = 1'b0;
    logic [0:0]   a1 = '0;
    logic [0:0]   b1 = '0;
    logic         cin1 = 1'b0;
    logic         busy1, done1, cout1;
    logic [0:0]   sum1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int avail = 0;
    int avail1 = 0;
    exp8_t sb[$];
    exp1_t sb1[$];
    logic [W:0] held = '0;
    logic [1:0] held1 = '0;

    serial_adder #(.WIDTH(W)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Called just after an edge; the inputs apply to edge cyc+1.
    task automatic drive(input bit st, input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        exp8_t e;
        start = st; a = av; b = bv; cin = ci;
        if (st && (cyc + 1) >= avail) begin
            e.res = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
            e.acc = cyc + 1;
            sb.push_back(e);
            avail = cyc + 1 + W + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic drive1(input bit st, input logic av, input logic bv, input logic ci);
        exp1_t e;
        start1 = st; a1 = av; b1 = bv; cin1 = ci;
        if (st && (cyc + 1) >= avail1) begin
            e.res = {1'b0, av} + {1'b0, bv} + {1'b0, ci};
            e.acc = cyc + 1;
            sb1.push_back(e);
            avail1 = cyc + 3;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", {cout, sum}, 0);
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_sum1", {cout1, sum1}, 0);
        sb.delete(); sb1.delete();
        held = '0; held1 = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        avail = cyc + 1;
        avail1 = cyc + 1;
    endtask

    always @(negedge clk) begin
        logic exp_busy;
        logic exp_done;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        foreach (sb[i])
            if (sb[i].acc <= cyc && cyc <= sb[i].acc + W - 1) exp_busy = 1'b1;
        if (sb.size() > 0 && sb[0].acc + W == cyc) begin
            exp_done = 1'b1;
            held = sb[0].res;
            void'(sb.pop_front());
        end
        check("busy8", busy, exp_busy);
        check("done8", done, exp_done);
        check("sum8", {cout, sum}, held);
    end

    always @(negedge clk) begin
        logic exp_busy;
        logic exp_done;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        foreach (sb1[i])
            if (sb1[i].acc == cyc) exp_busy = 1'b1;
        if (sb1.size() > 0 && sb1[0].acc + 1 == cyc) begin
            exp_done = 1'b1;
            held1 = sb1[0].res;
            void'(sb1.pop_front());
        end
        check("busy1", busy1, exp_busy);
        check("done1", done1, exp_done);
        check("sum1", {cout1, sum1}, held1);
    end

    initial begin
        #1;
        check("por_busy", busy, 0);
        check("por_sum", {cout, sum}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        avail = cyc + 1;
        avail1 = cyc + 1;

        // Plan vectors, each followed by idle cycles to drain.
        drive(1, 8'h5A, 8'h33, 0);
        repeat (10) drive(0, 8'h00, 8'h00, 0);
        drive(1, 8'hFF, 8'h01, 0);
        repeat (9) drive(0, 8'hFF, 8'hFF, 1);
        drive(1, 8'hFF, 8'hFF, 1);
        repeat (9) drive(0, 8'h00, 8'h00, 0);

        // Start while busy must be ignored.
        drive(1, 8'h10, 8'h20, 0);
        drive(0, 8'h00, 8'h00, 0);
        drive(1, 8'h01, 8'h01, 0);
        repeat (9) drive(0, 8'h00, 8'h00, 0);

        // Start held high: back-to-back accept in the DONE cycle.
        drive(1, 8'h0F, 8'h01, 0);
        repeat (9) drive(1, 8'h80, 8'h80, 0);
        drive(0, 8'h00, 8'h00, 0);
        repeat (9) drive(0, 8'h00, 8'h00, 0);

        // Reset in the middle of RUN, then a fresh operation.
        drive(1, 8'h55, 8'hAA, 1);
        repeat (3) drive(0, 8'h00, 8'h00, 0);
        do_reset();
        repeat (12) drive(0, 8'h00, 8'h00, 0);
        drive(1, 8'h02, 8'h03, 0);
        repeat (10) drive(0, 8'h00, 8'h00, 0);

        // Random stimulus with operands changing every cycle.
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 3) == 0, W'($urandom), W'($urandom), 1'($urandom));
        start = 1'b0;

        // WIDTH=1 instance.
        drive1(1, 1, 1, 1);
        repeat (3) drive1(0, 0, 0, 0);
        for (int i = 0; i < 40; i++)
            drive1($urandom_range(0, 1) == 1, 1'($urandom), 1'($urandom), 1'($urandom));
        start1 = 1'b0;

        for (int i = 0; i < 40 && (sb.size() + sb1.size()) != 0; i++) begin
            @(negedge clk); #1;
        end
        check("drain", sb.size() + sb1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one 1-bit full-adder cell and a registered carry.
- Adds one bit pair per clock, LSB first. Result is committed after WIDTH cycles.
- Operands come from an upstream producer under a start/busy/done handshake.
- Used wherever area matters more than latency. It is the sequential consumer of the 1-bit full-adder stage.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1 to 64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when the block can accept (IDLE or DONE)
- a  input  WIDTH  operand A; sampled at the accepting edge only
- b  input  WIDTH  operand B; sampled at the accepting edge only
- cin  input  1  carry-in; sampled at the accepting edge only
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse: sum/cout just updated
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  registered carry-out, held with sum

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - busy, done, sum, cout, carry register, shift registers and bit counter all = 0.
  - Reset takes effect immediately.
  - Release is synchronous to clk; first accept is possible at the first edge after rst_n rises.
- States: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. start=1 at edge E0 -> RUN:
    - a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, res_sh<=0.
  - RUN: busy=1, done=0. Each edge:
    - full-adder cell takes a_sh[0], b_sh[0], carry.
    - res_sh <= {s, res_sh[WIDTH-1:1]}.
    - a_sh and b_sh shift right with zero fill.
    - carry <= c.
    - cnt <= cnt+1.
  - RUN exit: on the edge where cnt==WIDTH-1 (the WIDTH-th RUN edge, E(WIDTH)):
    - sum <= final shifted result (including this cycle's bit); cout <= final carry.
    - state -> DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 at this edge -> accept new operands, enter RUN (back-to-back, no idle gap).
    - Otherwise -> IDLE.
- Latency: done is high in the cycle following edge E(WIDTH); throughput is one addition per WIDTH+1 cycles.
- busy rises after E0 and falls after E(WIDTH).
- sum/cout change only at the completion edge. Intermediate shift contents are never visible on sum.
- start while busy=1 is ignored; operands are not resampled. a, b and cin may change freely after E0.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- WIDTH=1: RUN lasts one edge; done follows after 2 edges total from start.
- Counter width: $clog2(WIDTH) minimum 1; it must not wrap before exit.
- Reset mid-RUN: the operation is abandoned, and sum/cout clear to 0. No done pulse until a new start completes.
- Unreachable state encodings recover to IDLE.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
  - default WIDTH constant.
- One sub-module: fa_bit (a, b, cin -> sum, cout; purely combinational).
  - Instantiated once; serial_adder contains only the sequential control and datapath registers.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h33, cin=0, start pulse -> busy high 8 cycles; done pulses once in cycle 9; sum=8'h8D, cout=0; sum stays 0 until that cycle.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start reasserted with a=8'h01, b=8'h01 at cycle 3 of an 8'h10+8'h20 operation -> ignored; result sum=8'h30, cout=0, single done pulse.
- start held high continuously, operand sets 8'h0F+8'h01 then 8'h80+8'h80 -> second op accepted in the DONE cycle; done pulses 9 cycles apart; results 8'h10/0 then 8'h00/1.
- rst_n low for 1 cycle at RUN cycle 4 -> busy, done, sum, cout = 0 immediately; no done pulse follows; next start with 8'h02+8'h03 gives 8'h05.
- WIDTH=1 build: a=1, b=1, cin=1 -> done in 2nd cycle after start, sum=1, cout=1.
